// File: rtl/seven_seg_scanner.sv
// Four-digit MM.SS multiplexer for a common-anode 7-segment display, fed by the kitchen-timer FSM.
// Latches one digit snapshot per frame, blanks anodes around slot changes and blinks while the alarm is up.
//
// state  | meaning
// BL_ON  | display enabled (also the state whenever led is low)
// BL_OFF | alarm blink half-period with all anodes off
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 128,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] min_1,
    input  logic [3:0] min_0,
    input  logic [3:0] sec_1,
    input  logic [3:0] sec_0,
    input  logic       led,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [BW-1:0] B_LAST  = BW'(BLINK_FRAMES - 1);

    typedef enum logic {
        BL_ON  = 1'b0,
        BL_OFF = 1'b1
    } blink_state_t;

    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_sel;
    logic [15:0]   r_snap;
    logic [BW-1:0] r_bcnt;
    blink_state_t  r_blink_state;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_tick;

    logic          w_tick;
    logic          w_snap_evt;
    logic          w_blink_on;
    logic          w_lz_blank;
    logic [3:0]    w_digit;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;
    logic [BW-1:0] w_bcnt_next;
    blink_state_t  w_blink_next;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;  // dash flags a non-BCD digit
        endcase
        return s;
    endfunction

    assign w_tick     = (r_pcnt == P_LAST);
    assign w_snap_evt = w_tick && (r_sel == 2'd3);
    assign w_blink_on = (r_blink_state == BL_ON);
    assign w_lz_blank = (LZ_SUPPRESS != 0) && (r_sel == 2'd3) && (r_snap[15:12] == 4'd0);

    always_comb begin
        w_digit = 4'd0;
        case (r_sel)
            2'd0: w_digit = r_snap[3:0];
            2'd1: w_digit = r_snap[7:4];
            2'd2: w_digit = r_snap[11:8];
            2'd3: w_digit = r_snap[15:12];
            default: w_digit = 4'd0;
        endcase
    end

    always_comb begin
        w_an  = 4'b1111;
        w_seg = f_decode(w_digit);
        w_dp  = (r_sel != 2'd2);
        if (!(r_pcnt < P_BLANK) && w_blink_on && !w_lz_blank) begin
            case (r_sel)
                2'd0: w_an = 4'b1110;
                2'd1: w_an = 4'b1101;
                2'd2: w_an = 4'b1011;
                2'd3: w_an = 4'b0111;
                default: w_an = 4'b1111;
            endcase
        end
    end

    // Blink counts frames via the snapshot event so OFF aligns with whole frames.
    always_comb begin
        w_blink_next = r_blink_state;
        w_bcnt_next  = r_bcnt;
        if (!led) begin
            w_blink_next = BL_ON;
            w_bcnt_next  = '0;
        end else if (w_snap_evt) begin
            if (r_bcnt == B_LAST) begin
                w_bcnt_next  = '0;
                w_blink_next = (r_blink_state == BL_ON) ? BL_OFF : BL_ON;
            end else begin
                w_bcnt_next = r_bcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink_state <= BL_ON;
            r_bcnt        <= '0;
        end else begin
            r_blink_state <= w_blink_next;
            r_bcnt        <= w_bcnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pcnt       <= '0;
            r_sel        <= 2'd0;
            r_snap       <= 16'h0000;
            r_frame_tick <= 1'b0;
            r_an         <= 4'b1111;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
        end else begin
            r_pcnt       <= w_tick ? '0 : r_pcnt + PW'(1);
            if (w_tick) begin
                r_sel <= r_sel + 2'd1;
            end
            if (w_snap_evt) begin
                r_snap <= {min_1, min_0, sec_1, sec_0};
            end
            r_frame_tick <= w_snap_evt;
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
